// File: rtl/fp_mac_accumulator.sv
// Streaming FP multiply-accumulate: fp_fma closed around a running sum, result emitted on the last beat.
// Optional input register stage: define FP_MAC_INPUT_REG_EN.

package fpnew_pkg_snax;
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            default: return 7;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction
endpackage

// Combinational a*b + c, round-to-nearest-even into format c. The product is kept exact.
module fp_fma #(
    parameter fpnew_pkg_snax::fp_format_e FpFormat_a = fpnew_pkg_snax::fp_format_e'(2),
    parameter fpnew_pkg_snax::fp_format_e FpFormat_b = fpnew_pkg_snax::fp_format_e'(2),
    parameter fpnew_pkg_snax::fp_format_e FpFormat_c = fpnew_pkg_snax::fp_format_e'(0),
    localparam int unsigned WIDTH_A = fpnew_pkg_snax::fp_width(FpFormat_a),
    localparam int unsigned WIDTH_B = fpnew_pkg_snax::fp_width(FpFormat_b),
    localparam int unsigned WIDTH_C = fpnew_pkg_snax::fp_width(FpFormat_c)
) (
    input  logic [WIDTH_A-1:0] operand_a_i,
    input  logic [WIDTH_B-1:0] operand_b_i,
    input  logic [WIDTH_C-1:0] operand_c_i,
    output logic [WIDTH_C-1:0] result_o
);
    localparam int EA = int'(fpnew_pkg_snax::exp_bits(FpFormat_a));
    localparam int MA = int'(fpnew_pkg_snax::man_bits(FpFormat_a));
    localparam int EB = int'(fpnew_pkg_snax::exp_bits(FpFormat_b));
    localparam int MB = int'(fpnew_pkg_snax::man_bits(FpFormat_b));
    localparam int EC = int'(fpnew_pkg_snax::exp_bits(FpFormat_c));
    localparam int MC = int'(fpnew_pkg_snax::man_bits(FpFormat_c));
    localparam int BIAS_A = (1 << (EA - 1)) - 1;
    localparam int BIAS_B = (1 << (EB - 1)) - 1;
    localparam int BIAS_C = (1 << (EC - 1)) - 1;
    localparam int EMIN = 1 - BIAS_C;
    localparam int EMAX_FIELD = (1 << EC) - 1;
    localparam int PW = MA + MB + 2;
    localparam int SW = (PW > MC + 1) ? PW : MC + 1;
    localparam int WW = SW + MC + 5;
    localparam int NW = WW + 2;
    localparam int MW = MC + 2;
    localparam logic [WIDTH_C-1:0] QNAN = {1'b0, {EC{1'b1}}, 1'b1, {(MC-1){1'b0}}};

    logic sign_a, sign_b, sign_c, sign_p;
    logic [EA-1:0] exp_a;
    logic [MA-1:0] man_a;
    logic [EB-1:0] exp_b;
    logic [MB-1:0] man_b;
    logic [EC-1:0] exp_c;
    logic [MC-1:0] man_c;
    logic [MA:0] sig_a;
    logic [MB:0] sig_b;
    logic [MC:0] sig_c;
    logic [PW-1:0] sig_p;
    logic a_inf, b_inf, c_inf, a_zero, b_zero, any_nan, p_inf, invalid;

    assign {sign_a, exp_a, man_a} = operand_a_i;
    assign {sign_b, exp_b, man_b} = operand_b_i;
    assign {sign_c, exp_c, man_c} = operand_c_i;
    assign sign_p = sign_a ^ sign_b;
    assign sig_a  = {|exp_a, man_a};
    assign sig_b  = {|exp_b, man_b};
    assign sig_c  = {|exp_c, man_c};
    assign sig_p  = PW'(sig_a) * PW'(sig_b);

    assign a_inf   = (&exp_a) && !(|man_a);
    assign b_inf   = (&exp_b) && !(|man_b);
    assign c_inf   = (&exp_c) && !(|man_c);
    assign a_zero  = !(|exp_a) && !(|man_a);
    assign b_zero  = !(|exp_b) && !(|man_b);
    assign any_nan = ((&exp_a) && (|man_a)) || ((&exp_b) && (|man_b)) || ((&exp_c) && (|man_c));
    assign p_inf   = a_inf || b_inf;
    assign invalid = (p_inf && (a_zero || b_zero)) || (p_inf && c_inf && (sign_p != sign_c));

    int e_a, e_b, e_c, lsb_p, lsb_c, lz_p, lz_c, lz_s, top_p, top_c, top_max;
    int sh_p, sh_c, lsb_win, e_r, exp_val, rs, biased;
    logic p_zero, c_zero, eff_sub, sign_r, guard, sticky;
    logic [SW-1:0] lj_p, lj_c;
    logic [WW-1:0] full_p, full_c;
    logic [WW:0] win_p, win_c;
    logic [NW-1:0] sum;
    logic [MW-1:0] mant, mant_r;

    always_comb begin
        e_a   = (exp_a == '0) ? 1 - BIAS_A : int'(exp_a) - BIAS_A;
        e_b   = (exp_b == '0) ? 1 - BIAS_B : int'(exp_b) - BIAS_B;
        e_c   = (exp_c == '0) ? 1 - BIAS_C : int'(exp_c) - BIAS_C;
        lsb_p = e_a - MA + e_b - MB;
        lsb_c = e_c - MC;
        lz_p  = PW;
        for (int i = 0; i < PW; i++) if (sig_p[i]) lz_p = PW - 1 - i;
        lz_c = MC + 1;
        for (int i = 0; i <= MC; i++) if (sig_c[i]) lz_c = MC - i;
        top_p  = lsb_p + PW - 1 - lz_p;
        top_c  = lsb_c + MC - lz_c;
        p_zero = (sig_p == '0);
        c_zero = (sig_c == '0);
        if (p_zero)      top_max = top_c;
        else if (c_zero) top_max = top_p;
        else             top_max = (top_p > top_c) ? top_p : top_c;

        // Left-justify both addends, then align to the larger; bit 0 of the window is a pure sticky bit.
        lj_p   = SW'(sig_p) << (SW - PW + lz_p);
        lj_c   = SW'(sig_c) << (SW - MC - 1 + lz_c);
        sh_p   = p_zero ? 0 : top_max - top_p;
        sh_c   = c_zero ? 0 : top_max - top_c;
        full_p = WW'(lj_p) << (WW - SW);
        full_c = WW'(lj_c) << (WW - SW);
        win_p  = {full_p >> sh_p, |(full_p & ~({WW{1'b1}} << sh_p))};
        win_c  = {full_c >> sh_c, |(full_c & ~({WW{1'b1}} << sh_c))};

        eff_sub = sign_p ^ sign_c;
        sign_r  = sign_p;
        if (!eff_sub) begin
            sum = NW'(win_p) + NW'(win_c);
        end else if (win_p >= win_c) begin
            sum = NW'(win_p - win_c);
        end else begin
            sum    = NW'(win_c - win_p);
            sign_r = sign_c;
        end

        lz_s = NW;
        for (int i = 0; i < NW; i++) if (sum[i]) lz_s = NW - 1 - i;
        lsb_win = top_max - WW;
        e_r     = lsb_win + NW - 1 - lz_s;
        exp_val = (e_r > EMIN) ? e_r : EMIN;
        rs      = exp_val - MC - lsb_win;
        guard   = 1'b0;
        sticky  = 1'b0;
        if (rs > 0) begin
            mant   = MW'(sum >> rs);
            guard  = (sum & (NW'(1) << (rs - 1))) != '0;
            sticky = |(sum & ~({NW{1'b1}} << (rs - 1)));
        end else begin
            mant = MW'(sum << (-rs));
        end
        mant_r = mant + MW'(guard & (sticky | mant[0]));
        if (mant_r[MC+1]) begin
            mant_r  = mant_r >> 1;
            exp_val = exp_val + 1;
        end
        biased = mant_r[MC] ? exp_val + BIAS_C : 0;

        result_o = {sign_r, EC'(biased), mant_r[MC-1:0]};
        if (biased >= EMAX_FIELD) result_o = {sign_r, {EC{1'b1}}, {MC{1'b0}}};
        if (sum == '0)            result_o = '0;
        if (p_zero && c_zero)     result_o = {sign_p & sign_c, {(WIDTH_C-1){1'b0}}};
        if (c_inf)                result_o = operand_c_i;
        if (p_inf)                result_o = {sign_p, {EC{1'b1}}, {MC{1'b0}}};
        if (any_nan || invalid)   result_o = QNAN;
    end
endmodule

module fp_mac_accumulator #(
    parameter fpnew_pkg_snax::fp_format_e FpFormat_a = fpnew_pkg_snax::fp_format_e'(2),
    parameter fpnew_pkg_snax::fp_format_e FpFormat_b = fpnew_pkg_snax::fp_format_e'(2),
    parameter fpnew_pkg_snax::fp_format_e FpFormat_c = fpnew_pkg_snax::fp_format_e'(0),
    parameter int unsigned CntWidth = 16,
    localparam int unsigned WIDTH_A = fpnew_pkg_snax::fp_width(FpFormat_a),
    localparam int unsigned WIDTH_B = fpnew_pkg_snax::fp_width(FpFormat_b),
    localparam int unsigned WIDTH_C = fpnew_pkg_snax::fp_width(FpFormat_c)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [WIDTH_A-1:0]  in_a_i,
    input  logic [WIDTH_B-1:0]  in_b_i,
    input  logic                in_first_i,
    input  logic                in_last_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [WIDTH_C-1:0]  out_result_o,
    output logic [CntWidth-1:0] out_count_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);
    typedef enum logic {ACCUM, HOLD} state_e;

    state_e state_q, state_d;
    logic [WIDTH_C-1:0] acc_q, fma_c, fma_result, out_result_q;
    logic [CntWidth-1:0] cnt_q, cnt_next, out_count_q;
    logic out_valid_q;
    logic [WIDTH_A-1:0] beat_a;
    logic [WIDTH_B-1:0] beat_b;
    logic beat_first, beat_last, beat_valid, beat_ready, beat_fire;

`ifdef FP_MAC_INPUT_REG_EN
    logic [WIDTH_A-1:0] stage_a_q;
    logic [WIDTH_B-1:0] stage_b_q;
    logic stage_first_q, stage_last_q, stage_valid_q;

    assign beat_a     = stage_a_q;
    assign beat_b     = stage_b_q;
    assign beat_first = stage_first_q;
    assign beat_last  = stage_last_q;
    assign beat_valid = stage_valid_q;
    // Non-last beats never touch the output register, so they drain even while a result is held.
    assign beat_ready = !stage_last_q || (state_q != HOLD) || out_ready_i;
    assign in_ready_o = !stage_valid_q || beat_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid_q <= 1'b0;
            stage_a_q     <= '0;
            stage_b_q     <= '0;
            stage_first_q <= 1'b0;
            stage_last_q  <= 1'b0;
        end else if (in_ready_o) begin
            stage_valid_q <= in_valid_i;
            if (in_valid_i) begin
                stage_a_q     <= in_a_i;
                stage_b_q     <= in_b_i;
                stage_first_q <= in_first_i;
                stage_last_q  <= in_last_i;
            end
        end
    end
`else
    assign beat_a     = in_a_i;
    assign beat_b     = in_b_i;
    assign beat_first = in_first_i;
    assign beat_last  = in_last_i;
    assign beat_valid = in_valid_i;
    assign beat_ready = (state_q == ACCUM) || out_ready_i;
    assign in_ready_o = beat_ready;
`endif

    assign beat_fire = beat_valid && beat_ready;
    assign fma_c     = beat_first ? '0 : acc_q;
    assign cnt_next  = beat_first ? CntWidth'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    fp_fma #(
        .FpFormat_a(FpFormat_a),
        .FpFormat_b(FpFormat_b),
        .FpFormat_c(FpFormat_c)
    ) i_fma (
        .operand_a_i(beat_a),
        .operand_b_i(beat_b),
        .operand_c_i(fma_c),
        .result_o   (fma_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (beat_fire && beat_last) state_d = HOLD;
            HOLD:    if (!(beat_fire && beat_last) && out_ready_i) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_result_q <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat_fire) begin
                if (beat_last) begin
                    out_result_q <= fma_result;
                    out_count_q  <= cnt_next;
                    acc_q        <= '0;
                    cnt_q        <= '0;
                end else begin
                    acc_q <= fma_result;
                    cnt_q <= cnt_next;
                end
            end
            if (beat_fire && beat_last) out_valid_q <= 1'b1;
            else if (out_ready_i)       out_valid_q <= 1'b0;
        end
    end

    assign out_result_o = out_result_q;
    assign out_count_o  = out_count_q;
    assign out_valid_o  = out_valid_q;
endmodule

// File: tb/tb_fp_mac_accumulator.sv
// Directed bench for fp_mac_accumulator (default build, FP16 x FP16 + FP32).
module tb_fp_mac_accumulator;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] in_a_i, in_b_i;
    logic        in_first_i, in_last_i, in_valid_i, in_ready_o;
    logic [31:0] out_result_o;
    logic [15:0] out_count_o;
    logic        out_valid_o, out_ready_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    fp_mac_accumulator dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .in_first_i  (in_first_i),
        .in_last_i   (in_last_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_result_o(out_result_o),
        .out_count_o (out_count_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat right after a rising edge; it is accepted at the next edge (DUT is ready here).
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic first, input logic last);
        in_a_i = a; in_b_i = b; in_first_i = first; in_last_i = last; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; in_first_i = 1'b0; in_last_i = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] res, input logic [15:0] cnt);
        $display("result %-8s value %h count %0d valid %0b", tag, out_result_o, out_count_o, out_valid_o);
        check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        check({tag, "_value"}, out_result_o, res);
        check({tag, "_count"}, {16'd0, out_count_o}, {16'd0, cnt});
    endtask

    task automatic tick;
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_ni = 1'b0; out_ready_i = 1'b1; in_valid_i = 1'b0;
        in_a_i = '0; in_b_i = '0; in_first_i = 1'b0; in_last_i = 1'b0;
        repeat (2) tick();
        check("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_value", out_result_o, 32'h0);
        check("rst_count", {16'd0, out_count_o}, 32'd0);
        rst_ni = 1'b1;
        tick();
        check("rst_ready", {31'd0, in_ready_o}, 32'd1);

        send(16'h3C00, 16'h3C00, 1'b1, 1'b0);
        check("two_mid_valid", {31'd0, out_valid_o}, 32'd0);
        send(16'h4000, 16'h4000, 1'b0, 1'b1);
        check_result("two", 32'h40A00000, 16'd2);
        tick();
        check("two_drop", {31'd0, out_valid_o}, 32'd0);

        send(16'h4200, 16'h4000, 1'b1, 1'b1);
        check_result("single", 32'h40C00000, 16'd1);
        tick();

        send(16'h3C00, 16'h3C00, 1'b1, 1'b0);
        send(16'h4000, 16'h4000, 1'b1, 1'b1);
        check_result("restart", 32'h40800000, 16'd1);
        tick();

        send(16'h3C00, 16'h3C00, 1'b1, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        send(16'h4200, 16'h4000, 1'b0, 1'b1);
        check_result("three", 32'h41300000, 16'd3);
        tick();

        send(16'h4000, 16'h4000, 1'b1, 1'b0);
        send(16'hC000, 16'h4000, 1'b0, 1'b1);
        check_result("cancel", 32'h00000000, 16'd2);
        tick();

        send(16'hC000, 16'h4000, 1'b1, 1'b1);
        check_result("neg", 32'hC0800000, 16'd1);
        tick();

        out_ready_i = 1'b0;
        send(16'h4200, 16'h4000, 1'b1, 1'b1);
        check_result("held", 32'h40C00000, 16'd1);
        check("held_ready", {31'd0, in_ready_o}, 32'd0);
        repeat (2) tick();
        check_result("stable", 32'h40C00000, 16'd1);
        in_a_i = 16'h3C00; in_b_i = 16'h3C00; in_first_i = 1'b0; in_last_i = 1'b1; in_valid_i = 1'b1;
        tick();
        check_result("blocked", 32'h40C00000, 16'd1);
        out_ready_i = 1'b1;
        #1;
        check("release_ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; in_last_i = 1'b0;
        check_result("overwr", 32'h3F800000, 16'd1);
        tick();
        check("overwr_drop", {31'd0, out_valid_o}, 32'd0);

        send(16'h7C00, 16'h0000, 1'b1, 1'b1);
        check_result("inf0", 32'h7FC00000, 16'd1);
        tick();

        send(16'h3C00, 16'h3C00, 1'b1, 1'b0);
        send(16'h3C00, 16'h3C00, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("rstmid_valid", {31'd0, out_valid_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        check("rstmid_count", {16'd0, out_count_o}, 32'd0);
        tick();
        check("rstmid_after", {31'd0, out_valid_o}, 32'd0);
        send(16'h3C00, 16'h3C00, 1'b0, 1'b1);
        check_result("postrst", 32'h3F800000, 16'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp_mac_accumulator.md
# fp_mac_accumulator

Streaming multiply-accumulate stage that wraps `fp_fma` combinationally and closes the accumulation loop around it. It consumes a valid/ready stream of (a, b) operand pairs and feeds the running sum back as operand c each beat. On the beat tagged last, it emits the reduced result in format c on a registered valid/ready output. It sits between the operand streamers and the writeback path of the SNAX FP datapath.

## Interface
- `FpFormat_a`, default `fpnew_pkg_snax::fp_format_e'(2)` (FP16): format of operand a.
- `FpFormat_b`, default `fpnew_pkg_snax::fp_format_e'(2)` (FP16): format of operand b.
- `FpFormat_c`, default `fpnew_pkg_snax::fp_format_e'(0)` (FP32): format of the accumulator and the result.
- `CntWidth`, default 16: width of the beat counter.
- `WIDTH_A`, `WIDTH_B`, `WIDTH_C`: `fpnew_pkg_snax::fp_width(...)` of the respective format. Derived; do not override.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `in_a_i`, in, WIDTH_A: operand a.
- `in_b_i`, in, WIDTH_B: operand b.
- `in_first_i`, in, 1: this beat starts a new reduction.
- `in_last_i`, in, 1: this beat ends the reduction.
- `in_valid_i`, in, 1: input beat valid.
- `in_ready_o`, out, 1: input beat accepted when `in_valid_i && in_ready_o`.
- `out_result_o`, out, WIDTH_C: reduced result.
- `out_count_o`, out, CntWidth: number of beats in the reduction.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: downstream accepts the result.

## Operation
- Registers: `acc_q` (WIDTH_C), `cnt_q` (CntWidth), the output register, and a two-state FSM (ACCUM, HOLD).
- FMA operands: `operand_a_i = in_a_i`, `operand_b_i = in_b_i`, `operand_c_i = in_first_i ? 0 : acc_q`.
  - `acc_q` returns to 0 after every last beat, so a beat without first after a completed reduction also starts from +0.
- Accepted non-last beat:
  - `acc_q <= fma_result`.
  - `cnt_q <= (first ? 1 : cnt_q+1)`, saturating at all-ones.
- Accepted last beat:
  - `out_result_o <= fma_result`.
  - `out_count_o <=` the updated count.
  - `out_valid_o <= 1`.
  - `acc_q <= 0`, `cnt_q <= 0`.
  - FSM goes to HOLD.
- FSM:
  - ACCUM: `in_ready_o = 1`.
  - HOLD: `in_ready_o = out_ready_i`.
  - HOLD→ACCUM when `out_ready_i` is high and no last beat is accepted in the same cycle.
  - HOLD→HOLD when a last beat is accepted in the same cycle; the output register is overwritten with the new result.
- Output handshake:
  - `out_valid_o` falls on `out_valid_o && out_ready_i` unless a new last beat is accepted that cycle.
  - `out_result_o` and `out_count_o` remain stable while `out_valid_o && !out_ready_i`.
- Special values (NaN, inf, inf×0) propagate exactly as `fp_fma` produces them. A NaN in `acc_q` persists until the reduction ends.
- `in_first_i && in_last_i` in one beat gives a single-product result, a*b + (+0).
- `in_first_i` mid-reduction discards the partial sum and resets the count to 1.

## Timing
- Reset values: `out_valid_o = 0`, `out_result_o = 0`, `out_count_o = 0`, `acc_q = 0`, `cnt_q = 0`, FSM = ACCUM. `in_ready_o = 1` once reset is released.
- Throughput: one beat per cycle.
- Latency: last beat accepted at edge N → `out_valid_o` high after edge N (visible in cycle N+1).
- Reset asserted mid-reduction clears all state immediately, with no output. The partial sum is lost.
- The FMA path is purely combinational from `acc_q` and the inputs to the registers: one FMA per cycle of timing budget.

## Configuration
- `FP_MAC_INPUT_REG_EN`, defined:
  - Adds a skid-free input register stage holding a, b, first, last and a valid bit.
  - The FMA consumes the registered beat.
  - `in_ready_o` is high when the stage is empty, or when it drains this cycle (holds a non-last beat, or FSM not in HOLD, or `out_ready_i` high).
  - Latency becomes 2 cycles (valid in cycle N+2).
  - Throughput stays one beat per cycle.
  - Reset clears the stage valid bit.
- `FP_MAC_INPUT_REG_EN`, undefined: the purely combinational input described above.

## Test plan
- Beat (0x3C00, 0x3C00, first), then beat (0x4000, 0x4000, last) → `out_result_o = 0x40A00000` (5.0), `out_count_o = 2`, one cycle after the last beat.
- Single beat (0x4200, 0x4000, first, last) → `0x40C00000` (6.0), count 1.
- Beats 1×1, then (0x4000, 0x4000, first, last) → `0x40800000` (4.0), count 1 (partial sum discarded).
- Hold `out_ready_i = 0` after a result → result and count stay stable and `in_ready_o = 0`. Then raise `out_ready_i` with a new last beat valid (0x3C00×0x3C00) → beat accepted the same cycle, output becomes `0x3F800000`, `out_valid_o` stays 1.
- Beat (0x7C00 = +inf, 0x0000, first, last) → `0x7FC00000` (canonical qNaN).
- Drop `rst_ni` after two accumulating beats, release it, then send (0x3C00, 0x3C00, last) → `0x3F800000`, count 1. No output during or after reset until that beat.
